data_mem_responder: RTL



---
 rtl/mem_pkg.sv | 41 ++++
 rtl/load_store_align.sv | 58 +++++
 rtl/data_mem_responder.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data memory responder: access-size codes,
// FSM states and the request legality checks.
package mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // i_off is the 33-bit difference addr - base; bit 32 set means underflow.
   function automatic logic addr_in_range(input logic [32:0] i_off,
                                          input logic [32:0] i_limit);
      return (i_off[32] == 1'b0) && (i_off < i_limit);
   endfunction

   function automatic logic addr_misaligned(input logic [2:0] i_f3,
                                            input logic [1:0] i_lane);
      case (i_f3)
         F3_H, F3_HU: return i_lane[0];
         F3_W:        return (i_lane != 2'b00);
         default:     return 1'b0;
      endcase
   endfunction

   function automatic logic funct3_legal(input logic [2:0] i_f3,
                                         input logic       i_is_store);
      case (i_f3)
         F3_B, F3_H, F3_W: return 1'b1;
         F3_BU, F3_HU:     return !i_is_store;
         default:          return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/load_store_align.sv
// Lane selection with sign/zero extension for loads, and byte merge of
// right-aligned store data into the addressed word for stores.
module load_store_align
   import mem_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_lane,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_load,
   output logic [31:0] o_store
);

   logic [31:0] w_shift;

   assign w_shift = i_word >> {i_lane, 3'b000};

   // Load extraction: addressed lane(s) shifted down, then extended.
   always_comb begin
      o_load = 32'd0;
      case (i_funct3)
         F3_B:    o_load = {{24{w_shift[7]}}, w_shift[7:0]};
         F3_H:    o_load = {{16{w_shift[15]}}, w_shift[15:0]};
         F3_W:    o_load = i_word;
         F3_BU:   o_load = {24'd0, w_shift[7:0]};
         F3_HU:   o_load = {16'd0, w_shift[15:0]};
         default: o_load = 32'd0;
      endcase
   end

   // Store merge: only the addressed lanes take new data.
   always_comb begin
      o_store = i_word;
      for (int k = 0; k < 4; k++) begin
         case (i_funct3)
            F3_B: begin
               if (2'(k) == i_lane) begin
                  o_store[8*k +: 8] = i_wdata[7:0];
               end else begin
                  o_store[8*k +: 8] = i_word[8*k +: 8];
               end
            end
            F3_H: begin
               if (2'(k) == {i_lane[1], 1'b0}) begin
                  o_store[8*k +: 8] = i_wdata[7:0];
               end else if (2'(k) == {i_lane[1], 1'b1}) begin
                  o_store[8*k +: 8] = i_wdata[15:8];
               end else begin
                  o_store[8*k +: 8] = i_word[8*k +: 8];
               end
            end
            F3_W:    o_store[8*k +: 8] = i_wdata[8*k +: 8];
            default: o_store[8*k +: 8] = i_word[8*k +: 8];
         endcase
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// Word-organised data RAM behind a valid/ready request port, with a
// configurable number of wait states before a one-cycle response.
module data_mem_responder
   import mem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 256,
   parameter int          WAIT_CYCLES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        resp_valid,
   output logic [31:0] rdata,
   output logic        resp_err
);

   localparam int          AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int          CW          = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [32:0] LIMIT_BYTES = 33'(DEPTH_WORDS) << 2;

   state_t        r_state;
   state_t        w_next;
   logic [CW-1:0] r_cnt;
   logic          r_rd;
   logic          r_wr;
   logic [2:0]    r_f3;
   logic [31:0]   r_addr;
   logic [31:0]   r_wdata;
   logic [31:0]   r_mem [DEPTH_WORDS];

   logic          r_req_ready;
   logic          r_resp_valid;
   logic [31:0]   r_rdata;
   logic          r_resp_err;

   logic          w_accept;
   logic          w_enter_resp;
   logic          w_rd;
   logic          w_wr;
   logic [2:0]    w_f3;
   logic [31:0]   w_addr;
   logic [31:0]   w_wdata;
   logic [32:0]   w_off;
   logic [AW-1:0] w_idx;
   logic [31:0]   w_word;
   logic [31:0]   w_load;
   logic [31:0]   w_store;
   logic          w_err;

   // With zero wait states the RAM is accessed on the acceptance edge itself,
   // so the request comes straight from the ports while still in IDLE.
   assign w_rd    = (r_state == IDLE) ? mem_read  : r_rd;
   assign w_wr    = (r_state == IDLE) ? mem_write : r_wr;
   assign w_f3    = (r_state == IDLE) ? funct3    : r_f3;
   assign w_addr  = (r_state == IDLE) ? addr      : r_addr;
   assign w_wdata = (r_state == IDLE) ? wdata     : r_wdata;

   assign w_off  = {1'b0, w_addr} - {1'b0, BASE_ADDR};
   assign w_idx  = w_off[AW+1:2];
   assign w_word = r_mem[w_idx];
   assign w_err  = (w_rd == w_wr)
                 || !funct3_legal(w_f3, w_wr)
                 || !addr_in_range(w_off, LIMIT_BYTES)
                 || addr_misaligned(w_f3, w_off[1:0]);

   load_store_align u_align (
      .i_word   (w_word),
      .i_lane   (w_off[1:0]),
      .i_funct3 (w_f3),
      .i_wdata  (w_wdata),
      .o_load   (w_load),
      .o_store  (w_store)
   );

   // Next-state decode and request acceptance.
   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      case (r_state)
         IDLE: begin
            if (req_valid) begin
               w_accept = 1'b1;
               w_next   = (WAIT_CYCLES == 0) ? RESP : WAIT;
            end else begin
               w_next = IDLE;
            end
         end
         WAIT: begin
            if (r_cnt == '0) begin
               w_next = RESP;
            end else begin
               w_next = WAIT;
            end
         end
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   assign w_enter_resp = (w_next == RESP);

   // State, request latch, wait counter and registered response outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_rd         <= 1'b0;
         r_wr         <= 1'b0;
         r_f3         <= 3'b000;
         r_addr       <= 32'd0;
         r_wdata      <= 32'd0;
         r_req_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_rdata      <= 32'd0;
         r_resp_err   <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_req_ready  <= (w_next == IDLE);
         r_resp_valid <= w_enter_resp;
         if (w_accept) begin
            r_rd    <= mem_read;
            r_wr    <= mem_write;
            r_f3    <= funct3;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_cnt   <= CW'(WAIT_CYCLES - 1);
         end else if ((r_state == WAIT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
         end
         if (w_enter_resp) begin
            r_rdata    <= (w_rd && !w_err) ? w_load : 32'd0;
            r_resp_err <= w_err;
         end else begin
            r_rdata    <= 32'd0;
            r_resp_err <= 1'b0;
         end
      end
   end

   // Store commit; reset on the same edge drops the write.
   always_ff @(posedge clk) begin
      if (!rst && w_enter_resp && w_wr && !w_err) begin
         r_mem[w_idx] <= w_store;
      end
   end

   assign req_ready  = r_req_ready;
   assign resp_valid = r_resp_valid;
   assign rdata      = r_rdata;
   assign resp_err   = r_resp_err;

endmodule
